// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction-fetch stage and its branch target
// buffer:
//   - 2-bit saturating counter encodings (SNT, WNT, WT, ST)
//   - btb_idx_w(): index width of the BTB for a given entry count
//   - btb_entry_t: per-entry control fields of a BTB entry
//
// The tag and target fields of a BTB entry depend on XLEN and BTB_ENTRIES,
// which are module parameters. A package typedef cannot follow them, so
// those two fields live in parallel arrays inside fetch_btb, indexed like the
// btb_entry_t array. Together they form the logical entry
// {valid, tag, target, is_jump, ctr}.
// -----------------------------------------------------------------------------
package fetch_pkg;

  // Direction counter encodings. The MSB is the predicted direction.
  localparam logic [1:0] SNT = 2'b00;  // strongly not-taken
  localparam logic [1:0] WNT = 2'b01;  // weakly not-taken
  localparam logic [1:0] WT  = 2'b10;  // weakly taken (allocation value)
  localparam logic [1:0] ST  = 2'b11;  // strongly taken

  // Number of PC bits used to index a BTB with 'entries' entries.
  function automatic int btb_idx_w(input int entries);
    return $clog2(entries);
  endfunction

  // Control part of one BTB entry.
  typedef struct packed {
    logic       valid;
    logic       is_jump;
    logic [1:0] ctr;
  } btb_entry_t;

endpackage

// File: rtl/fetch_btb.sv
// -----------------------------------------------------------------------------
// fetch_btb
// Direct-mapped branch target buffer with 2-bit saturating direction
// counters. Lookup is purely combinational on the fetch PC. Update happens at
// the clock edge from the resolution port. A lookup and an update on the same
// index in the same cycle see the old contents (no write-through).
//
// Parameters:
//   XLEN         PC width in bits
//   BTB_ENTRIES  number of entries (power of 2, at least 2)
//
// Ports:
//   clock          system clock
//   reset          asynchronous, active-low; clears every valid bit and counter
//   lookup_word    fetch PC without its two byte-offset bits
//   lookup_taken   entry hits and predicts taken (jump, or counter MSB set)
//   lookup_target  stored target of the indexed entry
//   upd_valid      a control instruction resolves this cycle
//   upd_word       PC of the resolving instruction without byte-offset bits
//   upd_is_jump    resolving instruction is an unconditional jump
//   upd_taken      actual direction
//   upd_target     actual target
// -----------------------------------------------------------------------------
module fetch_btb
  import fetch_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BTB_ENTRIES = 16
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [XLEN-3:0] lookup_word,
  output logic            lookup_taken,
  output logic [XLEN-1:0] lookup_target,
  input  logic            upd_valid,
  input  logic [XLEN-3:0] upd_word,
  input  logic            upd_is_jump,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target
);

  localparam int IDX_W = btb_idx_w(BTB_ENTRIES);
  localparam int TAG_W = XLEN - 2 - IDX_W;

  // Entry storage: control fields are reset, tag/target are plain data.
  btb_entry_t       meta_reg   [BTB_ENTRIES];
  logic [TAG_W-1:0] tag_reg    [BTB_ENTRIES];
  logic [XLEN-1:0]  target_reg [BTB_ENTRIES];

  // ---------------------------------------------------------------------------
  // Lookup
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;

  assign lk_idx = lookup_word[IDX_W-1:0];
  assign lk_tag = lookup_word[XLEN-3:IDX_W];
  assign lk_hit = meta_reg[lk_idx].valid && (tag_reg[lk_idx] == lk_tag);

  // Jumps always predict taken once they are in the table; branches follow
  // the counter MSB.
  assign lookup_taken  = lk_hit && (meta_reg[lk_idx].is_jump || meta_reg[lk_idx].ctr[1]);
  assign lookup_target = target_reg[lk_idx];

  // ---------------------------------------------------------------------------
  // Update
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;
  logic             up_train;   // existing entry: retrain counter / fields
  logic             up_alloc;   // taken miss: claim the slot
  logic [1:0]       up_ctr;
  btb_entry_t       up_new;

  assign up_idx = upd_word[IDX_W-1:0];
  assign up_tag = upd_word[XLEN-3:IDX_W];
  assign up_hit = meta_reg[up_idx].valid && (tag_reg[up_idx] == up_tag);

  assign up_train = upd_valid && up_hit;
  // A not-taken miss carries no useful target, so it never allocates.
  assign up_alloc = upd_valid && !up_hit && upd_taken;

  // Saturating counter step for a hit.
  always_comb begin
    up_ctr = meta_reg[up_idx].ctr;
    unique case (meta_reg[up_idx].ctr)
      SNT:     up_ctr = upd_taken ? WNT : SNT;
      WNT:     up_ctr = upd_taken ? WT  : SNT;
      WT:      up_ctr = upd_taken ? ST  : WNT;
      default: up_ctr = upd_taken ? ST  : WT;
    endcase
  end

  always_comb begin
    up_new         = '0;
    up_new.valid   = 1'b1;
    up_new.is_jump = upd_is_jump;
    up_new.ctr     = up_hit ? up_ctr : WT;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        meta_reg[i] <= '0;
      end
    end else if (up_train || up_alloc) begin
      meta_reg[up_idx] <= up_new;
    end
  end

  // Tag only changes on allocation (a hit already matches). The target is
  // refreshed on every taken resolution so moved targets are learned.
  always_ff @(posedge clock) begin
    if (up_alloc) begin
      tag_reg[up_idx] <= up_tag;
    end
    if (up_alloc || (up_train && upd_taken)) begin
      target_reg[up_idx] <= upd_target;
    end
  end

endmodule

// File: rtl/fetch_predict_unit.sv
// -----------------------------------------------------------------------------
// fetch_predict_unit
// Instruction-fetch stage of the 5-stage pipeline. Owns the PC and the IF/ID
// register and predicts control flow with a direct-mapped BTB (fetch_btb).
// Resolved control flow from later stages trains the BTB; a mispredict
// redirects the PC and raises flush_o in the same cycle.
//
// Optional feature (macro FETCH_PERF_COUNTERS_EN):
//   defined   -> adds perf_branches_o / perf_mispredicts_o event counters
//   undefined -> those ports and counters do not exist
//
// Parameters:
//   XLEN         datapath/PC width
//   BTB_ENTRIES  BTB entries (power of 2, at least 2)
//   RESET_PC     PC loaded on reset
//
// Ports:
//   clock, reset              clock; asynchronous active-low reset
//   stall_i                   hold PC and IF/ID (load-use hazard)
//   imem_addr_o/imem_rdata_i  instruction memory, same-cycle read
//   ifid_*                    IF/ID register contents
//   res_*                     resolution report from a later stage
//   flush_o                   mispredict this cycle (combinational)
//   perf_*                    event counters (only with the macro above)
// -----------------------------------------------------------------------------
module fetch_predict_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter int              BTB_ENTRIES = 16,
  parameter logic [XLEN-1:0] RESET_PC    = '0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            stall_i,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic [31:0]     imem_rdata_i,
  output logic            ifid_valid_o,
  output logic [31:0]     ifid_instr_o,
  output logic [XLEN-1:0] ifid_pcplus4_o,
  output logic            ifid_pred_taken_o,
  output logic [XLEN-1:0] ifid_pred_target_o,
  input  logic            res_valid_i,
  input  logic [XLEN-1:0] res_pc_i,
  input  logic            res_is_jump_i,
  input  logic            res_taken_i,
  input  logic [XLEN-1:0] res_target_i,
  input  logic            res_pred_taken_i,
  input  logic [XLEN-1:0] res_pred_target_i,
  output logic            flush_o
`ifdef FETCH_PERF_COUNTERS_EN
  ,
  output logic [31:0]     perf_branches_o,
  output logic [31:0]     perf_mispredicts_o
`endif
);

  logic [XLEN-1:0] pc_reg;
  logic [XLEN-1:0] pc_next;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] redirect_pc;
  logic            mispredict;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;

  logic            ifid_valid_reg;
  logic [31:0]     ifid_instr_reg;
  logic [XLEN-1:0] ifid_pcplus4_reg;
  logic            ifid_pred_taken_reg;
  logic [XLEN-1:0] ifid_pred_target_reg;

  // ---------------------------------------------------------------------------
  // Prediction
  // ---------------------------------------------------------------------------
  fetch_btb #(
    .XLEN        (XLEN),
    .BTB_ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clock         (clock),
    .reset         (reset),
    .lookup_word   (pc_reg[XLEN-1:2]),
    .lookup_taken  (pred_taken),
    .lookup_target (pred_target),
    .upd_valid     (res_valid_i),
    .upd_word      (res_pc_i[XLEN-1:2]),
    .upd_is_jump   (res_is_jump_i),
    .upd_taken     (res_taken_i),
    .upd_target    (res_target_i)
  );

  // ---------------------------------------------------------------------------
  // Mispredict detection. A correct "taken" prediction also needs the right
  // target; a correct "not-taken" prediction ignores the carried target.
  // ---------------------------------------------------------------------------
  assign mispredict = res_valid_i &&
                      ((res_taken_i != res_pred_taken_i) ||
                       (res_taken_i && (res_target_i != res_pred_target_i)));

  assign flush_o     = mispredict;
  assign redirect_pc = res_taken_i ? res_target_i : (res_pc_i + XLEN'(4));

  // ---------------------------------------------------------------------------
  // PC
  // ---------------------------------------------------------------------------
  assign pc_plus4    = pc_reg + XLEN'(4);
  assign imem_addr_o = pc_reg;

  // The redirect beats the stall: the stalled instruction is on the wrong
  // path anyway and gets squashed by the flush.
  always_comb begin
    pc_next = pc_plus4;
    if (mispredict) begin
      pc_next = redirect_pc;
    end else if (stall_i) begin
      pc_next = pc_reg;
    end else if (pred_taken) begin
      pc_next = pred_target;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_reg <= RESET_PC;
    end else begin
      pc_reg <= pc_next;
    end
  end

  // ---------------------------------------------------------------------------
  // IF/ID register. A squashed slot is cleared completely so downstream sees
  // an all-zero NOP with no prediction attached.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ifid_valid_reg       <= 1'b0;
      ifid_instr_reg       <= '0;
      ifid_pcplus4_reg     <= '0;
      ifid_pred_taken_reg  <= 1'b0;
      ifid_pred_target_reg <= '0;
    end else if (mispredict) begin
      ifid_valid_reg       <= 1'b0;
      ifid_instr_reg       <= '0;
      ifid_pcplus4_reg     <= '0;
      ifid_pred_taken_reg  <= 1'b0;
      ifid_pred_target_reg <= '0;
    end else if (!stall_i) begin
      ifid_valid_reg       <= 1'b1;
      ifid_instr_reg       <= imem_rdata_i;
      ifid_pcplus4_reg     <= pc_plus4;
      ifid_pred_taken_reg  <= pred_taken;
      ifid_pred_target_reg <= pred_taken ? pred_target : '0;
    end
  end

  assign ifid_valid_o       = ifid_valid_reg;
  assign ifid_instr_o       = ifid_instr_reg;
  assign ifid_pcplus4_o     = ifid_pcplus4_reg;
  assign ifid_pred_taken_o  = ifid_pred_taken_reg;
  assign ifid_pred_target_o = ifid_pred_target_reg;

`ifdef FETCH_PERF_COUNTERS_EN
  // ---------------------------------------------------------------------------
  // Event counters; they wrap silently.
  // ---------------------------------------------------------------------------
  logic [31:0] perf_branches_reg;
  logic [31:0] perf_mispredicts_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_branches_reg    <= '0;
      perf_mispredicts_reg <= '0;
    end else begin
      if (res_valid_i) begin
        perf_branches_reg <= perf_branches_reg + 32'd1;
      end
      if (mispredict) begin
        perf_mispredicts_reg <= perf_mispredicts_reg + 32'd1;
      end
    end
  end

  assign perf_branches_o    = perf_branches_reg;
  assign perf_mispredicts_o = perf_mispredicts_reg;
`endif

endmodule
